// File: rtl/spi_master_pkg.sv
// ============================================================================
// Module      : spi_master_pkg
// Description : Shared types and register-field positions for the SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_master_pkg;

    localparam int c_MAX_DATA_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } spi_state_t;

    // Setup register field positions (GPMC-mapped register file)
    localparam int c_SETUP_RST_BIT   = 0;
    localparam int c_SETUP_START_BIT = 1;
    localparam int c_SETUP_CPOL_BIT  = 2;
    localparam int c_SETUP_CPHA_BIT  = 3;
    localparam int c_SETUP_CS_BIT    = 4;
    localparam int c_SETUP_BPW_LSB   = 5;
    localparam int c_SETUP_BPW_MSB   = 9;
    localparam int c_SETUP_DIV_LSB   = 10;
    localparam int c_SETUP_DIV_MSB   = 15;

    // Status register field positions
    localparam int c_STATUS_BUSY_BIT     = 0;
    localparam int c_STATUS_NEW_DATA_BIT = 1;

endpackage

`default_nettype wire

// File: rtl/spi_master_clk_div.sv
// ============================================================================
// Module      : spi_clk_div
// Description : SCK half-period counter producing phase and edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_clk_div (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [5:0] i_div,
    output logic       o_lead_edge,
    output logic       o_trail_edge,
    output logic       o_phase
);

    logic [5:0] r_cnt;
    logic       r_phase;
    logic       w_tick;

    // A tick marks the last cycle of a half-period; the phase flips on it.
    assign w_tick = i_en && (r_cnt == i_div);

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt   <= 6'd0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= 6'd0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 6'd1;
        end
    end

    assign o_lead_edge  = w_tick & ~r_phase;
    assign o_trail_edge = w_tick &  r_phase;
    assign o_phase      = r_phase;

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// Module      : spi_master
// Description : Single-word SPI master, 1..32 bits, all CPOL/CPHA modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master
    import spi_master_pkg::*;
#(
    parameter int MAX_DATA_WIDTH = c_MAX_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      cpol,
    input  logic                      cpha,
    input  logic [4:0]                bits_per_word,
    input  logic [5:0]                div,
    input  logic [MAX_DATA_WIDTH-1:0] data_in,
    output logic [MAX_DATA_WIDTH-1:0] data_out,
    input  logic                      miso,
    output logic                      mosi,
    output logic                      sck,
    output logic                      busy,
    output logic                      new_data
);

    localparam int c_SHW = $clog2(MAX_DATA_WIDTH + 1);

    spi_state_t                r_state;
    logic                      r_start_q;
    logic                      r_cpol;
    logic                      r_cpha;
    logic [4:0]                r_bpw;
    logic [5:0]                r_div;
    logic [MAX_DATA_WIDTH-1:0] r_tx;
    logic [MAX_DATA_WIDTH-1:0] r_rx;
    logic [MAX_DATA_WIDTH-1:0] r_data_out;
    logic [5:0]                r_half_cnt;
    logic                      r_busy;
    logic                      r_new_data;
    logic                      r_mosi;

    logic                      w_start_evt;
    logic                      w_en;
    logic                      w_lead;
    logic                      w_trail;
    logic                      w_phase;
    logic                      w_last;
    logic [c_SHW-1:0]          w_shamt;
    logic [MAX_DATA_WIDTH-1:0] w_tx_aligned;
    logic [MAX_DATA_WIDTH-1:0] w_rx_shift;
    logic [MAX_DATA_WIDTH-1:0] w_rx_final;

    assign w_start_evt = start & ~r_start_q;
    assign w_en        = (r_state == XFER);

    // TX word is left-aligned so the current bit always sits at the top.
    assign w_shamt      = c_SHW'(MAX_DATA_WIDTH - 1) - c_SHW'(bits_per_word);
    assign w_tx_aligned = data_in << w_shamt;

    assign w_rx_shift = {r_rx[MAX_DATA_WIDTH-2:0], miso};
    // With CPHA=1 the final sample lands on the very edge that completes.
    assign w_rx_final = r_cpha ? w_rx_shift : r_rx;
    assign w_last     = w_trail && (r_half_cnt == {r_bpw, 1'b1});

    spi_clk_div u_clk_div (
        .clk          (clk),
        .rst          (rst),
        .i_en         (w_en),
        .i_div        (r_div),
        .o_lead_edge  (w_lead),
        .o_trail_edge (w_trail),
        .o_phase      (w_phase)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_start_q  <= 1'b0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_bpw      <= 5'd0;
            r_div      <= 6'd0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_data_out <= '0;
            r_half_cnt <= 6'd0;
            r_busy     <= 1'b0;
            r_new_data <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_start_q <= start;
            case (r_state)
                IDLE: begin
                    if (w_start_evt) begin
                        r_state    <= XFER;
                        r_cpol     <= cpol;
                        r_cpha     <= cpha;
                        r_bpw      <= bits_per_word;
                        r_div      <= div;
                        r_tx       <= w_tx_aligned;
                        r_rx       <= '0;
                        r_half_cnt <= 6'd0;
                        r_busy     <= 1'b1;
                        r_new_data <= 1'b0;
                        r_mosi     <= cpha ? 1'b0 : w_tx_aligned[MAX_DATA_WIDTH-1];
                    end
                end
                XFER: begin
                    if (w_lead) begin
                        if (r_cpha) begin
                            r_mosi <= r_tx[MAX_DATA_WIDTH-1];
                            r_tx   <= {r_tx[MAX_DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            r_rx   <= w_rx_shift;
                        end
                    end
                    if (w_trail) begin
                        if (r_cpha) begin
                            r_rx   <= w_rx_shift;
                        end else begin
                            r_mosi <= r_tx[MAX_DATA_WIDTH-2];
                            r_tx   <= {r_tx[MAX_DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                    if (w_lead || w_trail) begin
                        r_half_cnt <= r_half_cnt + 6'd1;
                    end
                    if (w_last) begin
                        r_state    <= IDLE;
                        r_data_out <= w_rx_final;
                        r_new_data <= 1'b1;
                        r_busy     <= 1'b0;
                        r_mosi     <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sck      = (w_en ? r_cpol : cpol) ^ w_phase;
    assign mosi     = r_mosi;
    assign busy     = r_busy;
    assign new_data = r_new_data;
    assign data_out = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module      : tb_spi_master
// Description : Directed self-checking bench for spi_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cpol;
    logic        cpha;
    logic [4:0]  bits_per_word;
    logic [5:0]  div;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        miso;
    logic        mosi;
    logic        sck;
    logic        busy;
    logic        new_data;

    logic        loopback;
    logic        miso_drv;

    int n_pass  = 0;
    int n_total = 0;

    assign miso = loopback ? mosi : miso_drv;

    spi_master #(.MAX_DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cpol          (cpol),
        .cpha          (cpha),
        .bits_per_word (bits_per_word),
        .div           (div),
        .data_in       (data_in),
        .data_out      (data_out),
        .miso          (miso),
        .mosi          (mosi),
        .sck           (sck),
        .busy          (busy),
        .new_data      (new_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Raises start and follows the transfer until busy drops, counting busy
    // cycles and SCK leading edges; MISO is driven on leading edges.
    task automatic run_xfer(input logic [31:0] miso_word, input int n_bits, input int budget,
                            output int busy_cyc, output int pulses, output logic [31:0] mosi_bits);
        logic prev_sck;
        busy_cyc  = 0;
        pulses    = 0;
        mosi_bits = '0;
        prev_sck  = sck;
        start     = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cyc++;
            if (sck !== prev_sck && sck !== cpol) begin
                mosi_bits = {mosi_bits[30:0], mosi};
                if (pulses < n_bits) miso_drv = miso_word[n_bits-1-pulses];
                pulses++;
            end
            prev_sck = sck;
        end
    endtask

    int          bc;
    int          pc;
    logic [31:0] mb;
    int          hold_busy;

    initial begin
        rst = 1'b1; start = 1'b0; cpol = 1'b1; cpha = 1'b0;
        bits_per_word = 5'd0; div = 6'd0; data_in = '0;
        loopback = 1'b0; miso_drv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_sck",      {31'd0, sck},      32'd1);
        chk("rst_mosi",     {31'd0, mosi},     32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_new_data", {31'd0, new_data}, 32'd0);
        chk("rst_data_out", data_out,          32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0, N=8, div=0, loopback
        cpol = 1'b0; cpha = 1'b0; bits_per_word = 5'd7; div = 6'd0;
        data_in = 32'h0000_00A5; loopback = 1'b1;
        run_xfer(32'd0, 8, 40, bc, pc, mb);
        start = 1'b0;
        chk("m0_busy_cycles", bc,       32'd16);
        chk("m0_pulses",      pc,       32'd8);
        chk("m0_mosi_bits",   mb,       32'h0000_00A5);
        chk("m0_data_out",    data_out, 32'h0000_00A5);
        chk("m0_new_data",    {31'd0, new_data}, 32'd1);
        loopback = 1'b0;
        @(negedge clk);

        // Mode 3, N=32, div=3
        cpol = 1'b1; cpha = 1'b1; bits_per_word = 5'd31; div = 6'd3;
        data_in = 32'hDEAD_BEEF; miso_drv = 1'b0;
        run_xfer(32'h2493_DB3D, 32, 300, bc, pc, mb);
        start = 1'b0;
        chk("m3_busy_cycles", bc,       32'd256);
        chk("m3_pulses",      pc,       32'd32);
        chk("m3_mosi_bits",   mb,       32'hDEAD_BEEF);
        chk("m3_data_out",    data_out, 32'h2493_DB3D);
        chk("m3_sck_idle",    {31'd0, sck}, 32'd1);
        @(negedge clk);

        // Mode 1, N=1, div=5, miso=1; start stays high afterwards
        cpol = 1'b0; cpha = 1'b1; bits_per_word = 5'd0; div = 6'd5;
        data_in = 32'h0000_0001; miso_drv = 1'b0;
        run_xfer(32'h0000_0001, 1, 40, bc, pc, mb);
        chk("m1_busy_cycles", bc,       32'd12);
        chk("m1_pulses",      pc,       32'd1);
        chk("m1_data_out",    data_out, 32'h0000_0001);
        chk("m1_new_data",    {31'd0, new_data}, 32'd1);

        // Holding start must not retrigger
        hold_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) hold_busy++;
        end
        chk("hold_no_retrigger", hold_busy, 32'd0);
        chk("hold_new_data",     {31'd0, new_data}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("retrig_busy",     {31'd0, busy},     32'd1);
        chk("retrig_new_data", {31'd0, new_data}, 32'd0);
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        start = 1'b0;
        chk("retrig_done",     {31'd0, busy},     32'd0);
        chk("retrig_data_out", data_out,          32'h0000_0001);
        @(negedge clk);

        // Reset during the 5th half-period, with a coincident start event
        cpol = 1'b1; cpha = 1'b0; bits_per_word = 5'd7; div = 6'd2;
        data_in = 32'h0000_00FF;
        start = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            if (i == 2) start = 1'b0;
        end
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("abort_busy",     {31'd0, busy},     32'd0);
        chk("abort_sck",      {31'd0, sck},      32'd1);
        chk("abort_data_out", data_out,          32'd0);
        chk("abort_new_data", {31'd0, new_data}, 32'd0);
        chk("abort_mosi",     {31'd0, mosi},     32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("abort_no_start", {31'd0, busy},     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_master.md
# spi_master

Configurable single-word SPI master that shifts a 1–32-bit word out on MOSI and captures the same number of bits from MISO. All four CPOL/CPHA modes are supported, with SCK derived from the system clock by a programmable divider. It sits behind the GPMC-mapped register file: setup-register fields drive its control inputs, and `busy`/`new_data` feed the status register.

## Interface
- `MAX_DATA_WIDTH`, default 32: width of `data_in`/`data_out`; the maximum word length.
- `clk`, in, 1: single clock, the PLL-derived SPI domain clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: transfer request; rising-edge sensitive.
- `cpol`, in, 1: SCK idle level.
- `cpha`, in, 1: 0 = sample on leading edge; 1 = sample on trailing edge.
- `bits_per_word`, in, 5: word length N = `bits_per_word`+1 (1..32).
- `div`, in, 6: SCK half-period = `div`+1 clk cycles.
- `data_in`, in, MAX_DATA_WIDTH: TX word; bits [N-1:0] are sent MSB first.
- `data_out`, out, MAX_DATA_WIDTH: RX word, right-aligned in [N-1:0], upper bits 0.
- `miso`, in, 1: serial input.
- `mosi`, out, 1: serial output.
- `sck`, out, 1: serial clock.
- `busy`, out, 1: transfer in progress.
- `new_data`, out, 1: sticky completion flag.

## Operation
- States: IDLE, XFER.
- `start` is registered once; a start event is `start`=1 while the registered copy is 0.
- IDLE → XFER on a start event:
  - Latch `cpol`, `cpha`, N and `div`.
  - Load the TX shift register from `data_in`.
  - Clear the RX register.
  - Set `busy`=1, clear `new_data`.
- Start events during XFER are ignored and not queued. Holding `start` high never retriggers a transfer.
- `sck` = `cpol` XOR phase bit, using live `cpol` in IDLE and latched `cpol` in XFER. The phase bit toggles at the end of every half-period.
- CPHA=0:
  - `mosi` = TX MSB from the acceptance cycle onward.
  - On each leading edge, sample `miso` into RX LSB (shift left).
  - On each trailing edge, shift TX so the next bit appears on `mosi`.
- CPHA=1:
  - On each leading edge, shift out the next bit (first leading edge presents the MSB).
  - On each trailing edge, sample `miso`.
- Each transfer has exactly 2N half-periods, giving N SCK pulses.
- At the end of the last half-period:
  - `data_out` ← RX[N-1:0], zero-extended.
  - `new_data`=1, `busy`=0, return to IDLE.
- `data_out` holds its value until the next completion or reset.
- `mosi`=0 in IDLE.
- Config inputs changing during XFER have no effect.

## Timing
- Reset (any state, mid-transfer included) aborts any transfer, with:
  - `busy`=0, `new_data`=0, `data_out`=0, `mosi`=0.
  - Phase bit 0, so `sck`=`cpol`.
  - State IDLE; the registered `start` copy is cleared.
- Reset takes priority over a simultaneous start event.
- A start event sampled at edge k gives `busy`=1 after edge k.
- The first SCK edge comes `div`+1 cycles later.
- `busy` falls, and `data_out`/`new_data` update, exactly 2N·(`div`+1) cycles after edge k.
- A new start event is accepted on the first cycle `busy`=0, which also clears `new_data`.
- Half-period counter is 6 bits; it reloads 0 at each edge and compares against the latched `div`.
- Bit counter is 6 bits wide to count up to 2N=64 half-periods.

## Structure
- Shared package:
  - `MAX_DATA_WIDTH` default.
  - State enum {IDLE, XFER}.
  - Setup-register bit positions: reset 0, start 1, cpol 2, cpha 3, cs 4, bpw 9:5, div 15:10.
  - Status bit positions: busy 0, new_data 1.
- One natural sub-module, `spi_clk_div`:
  - Half-period counter that emits one-cycle `lead_edge`/`trail_edge` strobes and the phase bit.
  - Shifter/FSM remain in `spi_master`.

## Test plan
- Reset with `cpol`=1 → `sck`=1, `mosi`=0, `busy`=0, `new_data`=0, `data_out`=0.
- Mode 0, N=8 (`bits_per_word`=7), `div`=0, `data_in`=0xA5, `miso` looped to `mosi` → MOSI 1,0,1,0,0,1,0,1; 8 pulses; `busy` high 16 cycles; `data_out`=0x000000A5; `new_data`=1.
- Mode 3, N=32, `div`=3, `data_in`=0xDEADBEEF, `miso` driven with 0x2493DB3D MSB-first on leading edges → `busy` high 256 cycles; `sck` idles 1; `data_out`=0x2493DB3D.
- Mode 1, N=1, `div`=5, `miso`=1 → one pulse; `busy` high 12 cycles; `data_out`=0x00000001.
- `start` held high through completion → no second transfer, `new_data` stays 1; drop then raise `start` → new transfer, `new_data` clears.
- `rst` asserted during the 5th half-period → next cycle `busy`=0, `sck`=`cpol`, `data_out`=0; a start event in the same cycle as `rst` is ignored.
